// File: rtl/aes_link_ctrl.sv
// Sequences received 128-bit blocks into the AES core and streams ciphertext bytes to the UART.
// Optional side-channel scope trigger enabled by defining SCA_TRIG_EN.
module aes_link_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    input  logic         key_reload,
    output logic [127:0] aes_key,
    output logic [127:0] aes_pt,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_ct,
    output logic [7:0]   tx_byte,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         busy,
    output logic         key_loaded,
    output logic         err_overrun,
    output logic         err_timeout,
    output logic         trig
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BCNT_W = 4;
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(15);

    typedef enum logic [2:0] {
        S_KEY_WAIT, S_IDLE, S_START, S_WAIT, S_SEND, S_HOLD, S_TXW
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   key_q, key_d, pt_q, pt_d, ct_q, ct_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               aes_start_q, aes_start_d, tx_start_q, tx_start_d;
    logic               busy_q, busy_d, key_loaded_q, key_loaded_d;
    logic               err_ovr_q, err_ovr_d, err_to_q, err_to_d;
    logic               pend_q, pend_d;
    logic               in_op, op_done;
`ifdef SCA_TRIG_EN
    logic               trig_q, trig_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        tx_byte_d    = tx_byte_q;
        bcnt_d       = bcnt_q;
        tcnt_d       = tcnt_q;
        aes_start_d  = 1'b0;
        tx_start_d   = 1'b0;
        key_loaded_d = key_loaded_q;
        err_ovr_d    = err_ovr_q;
        err_to_d     = err_to_q;
        pend_d       = pend_q;
        op_done      = 1'b0;
`ifdef SCA_TRIG_EN
        trig_d       = trig_q;
`endif
        in_op = (state_q != S_KEY_WAIT) && (state_q != S_IDLE);
        if (blk_valid && in_op)  err_ovr_d = 1'b1;
        if (key_reload && in_op) pend_d    = 1'b1;

        case (state_q)
            S_KEY_WAIT: begin
                if (blk_valid) begin
                    key_d        = blk_data;
                    key_loaded_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_IDLE: begin
                // A reload arriving with a block turns that block into the new key
                if (blk_valid && key_reload) begin
                    key_d  = blk_data;
                    pend_d = 1'b0;
                end else if (key_reload) begin
                    key_loaded_d = 1'b0;
                    pend_d       = 1'b0;
                    state_d      = S_KEY_WAIT;
                end else if (blk_valid) begin
                    pt_d    = blk_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                aes_start_d = 1'b1;
                tcnt_d      = '0;
                state_d     = S_WAIT;
`ifdef SCA_TRIG_EN
                trig_d      = 1'b1;
`endif
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                if (aes_done) begin
                    ct_d    = aes_ct;
                    bcnt_d  = '0;
                    state_d = S_SEND;
`ifdef SCA_TRIG_EN
                    trig_d  = 1'b0;
`endif
                end else if (tcnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    op_done  = 1'b1;
`ifdef SCA_TRIG_EN
                    trig_d   = 1'b0;
`endif
                end
            end
            S_SEND: begin
                tx_byte_d  = ct_q[{~bcnt_q, 3'b000} +: 8];
                tx_start_d = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: state_d = S_TXW;
            S_TXW: begin
                if (!tx_busy) begin
                    if (bcnt_q == BYTE_LAST) begin
                        op_done = 1'b1;
                    end else begin
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_KEY_WAIT;
        endcase

        // Finishing an operation honours any reload requested while busy
        if (op_done) begin
            if (pend_d) begin
                state_d      = S_KEY_WAIT;
                key_loaded_d = 1'b0;
                pend_d       = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end
        busy_d = (state_d != S_KEY_WAIT) && (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_KEY_WAIT;
            key_q        <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            tx_byte_q    <= '0;
            bcnt_q       <= '0;
            tcnt_q       <= '0;
            aes_start_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            key_loaded_q <= 1'b0;
            err_ovr_q    <= 1'b0;
            err_to_q     <= 1'b0;
            pend_q       <= 1'b0;
`ifdef SCA_TRIG_EN
            trig_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            tx_byte_q    <= tx_byte_d;
            bcnt_q       <= bcnt_d;
            tcnt_q       <= tcnt_d;
            aes_start_q  <= aes_start_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            key_loaded_q <= key_loaded_d;
            err_ovr_q    <= err_ovr_d;
            err_to_q     <= err_to_d;
            pend_q       <= pend_d;
`ifdef SCA_TRIG_EN
            trig_q       <= trig_d;
`endif
        end
    end

    assign aes_key     = key_q;
    assign aes_pt      = pt_q;
    assign aes_start   = aes_start_q;
    assign tx_byte     = tx_byte_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign key_loaded  = key_loaded_q;
    assign err_overrun = err_ovr_q;
    assign err_timeout = err_to_q;
`ifdef SCA_TRIG_EN
    assign trig        = trig_q;
`else
    assign trig        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_link_ctrl.sv
// Scoreboard bench for aes_link_ctrl: randomized blocks, AES and UART stubs, queue-based checking.
`timescale 1ns/1ps
module tb_aes_link_ctrl;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned CNT_W       = 5;
`ifdef SCA_TRIG_EN
    localparam logic TRIG_ON = 1'b1;
`else
    localparam logic TRIG_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid, key_reload, aes_done, tx_busy;
    logic [127:0] blk_data, aes_ct;
    logic [127:0] aes_key, aes_pt;
    logic         aes_start, tx_start, busy, key_loaded, err_overrun, err_timeout, trig;
    logic [7:0]   tx_byte;

    aes_link_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_data(blk_data),
        .key_reload(key_reload), .aes_key(aes_key), .aes_pt(aes_pt), .aes_start(aes_start),
        .aes_done(aes_done), .aes_ct(aes_ct), .tx_byte(tx_byte), .tx_start(tx_start),
        .tx_busy(tx_busy), .busy(busy), .key_loaded(key_loaded), .err_overrun(err_overrun),
        .err_timeout(err_timeout), .trig(trig)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [127:0] pt; int cyc; } pt_t;
    typedef struct { logic [7:0] b; int idx; } txe_t;
    pt_t  exp_pt_q[$];
    txe_t exp_tx_q[$];

    int checks = 0, errors = 0;
    int n_start = 0, n_tx = 0, last_tx_cyc = 0, done_cyc = 0;

    // Behavioural model of the link-level state
    logic [127:0] m_key = '0, m_pt = '0;
    bit m_loaded = 0, m_pend = 0, m_overrun = 0, m_timeout = 0;

    // Stub knobs
    int aes_lat = 11, aes_rem = 0, tx_hold = 0, busy_cnt = 0;
    bit aes_respond = 1, aes_active = 0, force_ct = 0;
    logic [127:0] forced_ct = '0, ct_v;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AES core stub: responds aes_lat cycles after aes_start with a bench-chosen ciphertext
    initial begin
        aes_done = 1'b0;
        aes_ct   = '0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (aes_start === 1'b1) begin
                aes_active = 1;
                aes_rem    = aes_lat;
            end
            if (aes_active) begin
                if (aes_rem == 0) begin
                    aes_active = 0;
                    if (aes_respond) begin
                        ct_v     = force_ct ? forced_ct : {$urandom, $urandom, $urandom, $urandom};
                        aes_ct   = ct_v;
                        aes_done = 1'b1;
                        done_cyc = cyc;
                        for (int i = 0; i < 16; i++)
                            exp_tx_q.push_back('{b: ct_v[127 - 8*i -: 8], idx: i});
                    end
                end else begin
                    aes_rem--;
                end
            end
        end
    end

    // UART transmitter stub: busy for tx_hold cycles starting with the tx_start cycle
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) busy_cnt = tx_hold;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt > 0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start or a byte
    initial begin
        pt_t  pe;
        txe_t te;
        forever begin
            @(negedge clk);
            if (aes_start === 1'b1) begin
                n_start++;
                check("aes_start_expected", 128'(exp_pt_q.size() != 0), 128'd1);
                if (exp_pt_q.size() != 0) begin
                    pe = exp_pt_q.pop_front();
                    check("aes_pt_at_start", aes_pt, pe.pt);
                    check("aes_key_at_start", aes_key, m_key);
                    check("blk_to_start_latency", 128'(cyc - pe.cyc), 128'd2);
                    check("trig_at_start", 128'(trig), 128'(TRIG_ON));
                end
            end
            if (tx_start === 1'b1) begin
                n_tx++;
                check("tx_start_expected", 128'(exp_tx_q.size() != 0), 128'd1);
                if (exp_tx_q.size() != 0) begin
                    te = exp_tx_q.pop_front();
                    check("tx_byte", 128'(tx_byte), 128'(te.b));
                    if (te.idx == 0) begin
                        check("done_to_tx_latency", 128'(cyc - done_cyc), 128'd2);
                        check("trig_after_done", 128'(trig), 128'd0);
                    end else begin
                        check("byte_gap", 128'(cyc - last_tx_cyc),
                              128'((tx_hold > 1) ? tx_hold + 2 : 3));
                    end
                end
                last_tx_cyc = cyc;
            end
        end
    end

    // Issue one block at the current negedge and predict its effect
    task automatic send_block(input logic [127:0] d, input bit reload, input bit expect_busy);
        if (expect_busy) begin
            m_overrun = 1;
            if (reload) m_pend = 1;
        end else if (!m_loaded) begin
            m_key    = d;
            m_loaded = 1;
        end else if (reload) begin
            m_key = d;
        end else begin
            m_pt = d;
            exp_pt_q.push_back('{pt: d, cyc: cyc});
        end
        blk_valid  = 1'b1;
        blk_data   = d;
        key_reload = reload;
        @(negedge clk);
        blk_valid  = 1'b0;
        key_reload = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(busy === 1'b0 && exp_tx_q.size() == 0 && !aes_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_reached"}, 128'(n < budget), 128'd1);
        if (m_pend) begin
            m_loaded = 0;
            m_pend   = 0;
        end
        check({tag, "_key_loaded"}, 128'(key_loaded), 128'(m_loaded));
        check({tag, "_err_overrun"}, 128'(err_overrun), 128'(m_overrun));
        check({tag, "_err_timeout"}, 128'(err_timeout), 128'(m_timeout));
        check({tag, "_aes_key"}, aes_key, m_key);
        check({tag, "_aes_pt"}, aes_pt, m_pt);
    endtask

    task automatic run_pt(input string tag, input int budget);
        int base = n_tx;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        wait_idle(tag, budget);
        check({tag, "_tx_count"}, 128'(n_tx - base), 128'd16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int base_tx, base_st, n, t_start;
        reset = 1'b0; blk_valid = 1'b0; key_reload = 1'b0; blk_data = '0;
        repeat (3) @(negedge clk);
        check("rst_aes_key", aes_key, 128'd0);
        check("rst_aes_pt", aes_pt, 128'd0);
        check("rst_flags", 128'({aes_start, tx_start, busy, key_loaded, err_overrun, err_timeout, trig}), 128'd0);
        check("rst_tx_byte", 128'(tx_byte), 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // Known-answer: key, then plaintext, fixed ciphertext
        send_block(128'h000102030405060708090a0b0c0d0e0f, 0, 0);
        check("kat_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
        check("kat_busy_after_key", 128'(busy), 128'd0);
        force_ct  = 1;
        forced_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        base_st   = n_start;
        base_tx   = n_tx;
        send_block(128'h00112233445566778899aabbccddeeff, 0, 0);
        wait_idle("kat", 200);
        check("kat_starts", 128'(n_start - base_st), 128'd1);
        check("kat_tx_count", 128'(n_tx - base_tx), 128'd16);
        force_ct = 0;

        // Random plaintexts with AES latency corners and varied UART busy time
        for (int i = 0; i < 6; i++) begin
            aes_lat = (i == 0) ? int'(TIMEOUT_CYC - 1) : (i == 1) ? 0 : int'($urandom_range(1, 14));
            tx_hold = int'($urandom_range(0, 3));
            run_pt("rand", 400);
        end

        // Key replaced from IDLE when reload accompanies the block
        base_st = n_start;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1, 0);
        repeat (4) @(negedge clk);
        check("idle_rekey_starts", 128'(n_start - base_st), 128'd0);
        wait_idle("idle_rekey", 20);

        // Timeout: AES never answers
        aes_respond = 0;
        aes_lat     = 3;
        base_tx     = n_tx;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        n = 0;
        while (aes_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("to_start_seen", 128'(n < 10), 128'd1);
        t_start = cyc;
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("to_delay", 128'(cyc - t_start), 128'(TIMEOUT_CYC));
        check("to_busy", 128'(busy), 128'd0);
        check("to_trig", 128'(trig), 128'd0);
        m_timeout = 1;
        wait_idle("timeout", 20);
        check("to_no_tx", 128'(n_tx - base_tx), 128'd0);
        aes_respond = 1;

        // Overrun: block arriving during WAIT is dropped
        aes_lat = 10;
        tx_hold = 1;
        base_st = n_start;
        base_tx = n_tx;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        repeat (3) @(negedge clk);
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1);
        wait_idle("overrun", 300);
        check("overrun_starts", 128'(n_start - base_st), 128'd1);
        check("overrun_tx_count", 128'(n_tx - base_tx), 128'd16);

        // Slow transmitter: busy 100 cycles per byte
        tx_hold = 100;
        aes_lat = 5;
        run_pt("slow_tx", 1900);

        // Key reload requested during TXW
        tx_hold = 4;
        base_tx = n_tx;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        n = 0;
        while (n_tx - base_tx < 3 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        key_reload = 1'b1;
        m_pend     = 1;
        @(negedge clk);
        key_reload = 1'b0;
        wait_idle("reload", 300);
        check("reload_tx_count", 128'(n_tx - base_tx), 128'd16);
        base_st = n_start;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        check("reload_new_key", aes_key, m_key);
        repeat (5) @(negedge clk);
        check("reload_no_start", 128'(n_start - base_st), 128'd0);
        check("reload_busy", 128'(busy), 128'd0);
        tx_hold = 0;
        run_pt("after_reload", 300);

        // Reset in the middle of a transfer
        base_tx = n_tx;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        n = 0;
        while (n_tx - base_tx < 7 && n < 200) begin @(negedge clk); n++; end
        reset = 1'b0;
        exp_tx_q.delete();
        exp_pt_q.delete();
        @(negedge clk);
        check("midrst_aes_key", aes_key, 128'd0);
        check("midrst_aes_pt", aes_pt, 128'd0);
        check("midrst_tx_byte", 128'(tx_byte), 128'd0);
        check("midrst_flags", 128'({aes_start, tx_start, busy, key_loaded, err_overrun, err_timeout, trig}), 128'd0);
        m_key = '0; m_pt = '0; m_loaded = 0; m_pend = 0; m_overrun = 0; m_timeout = 0;
        @(negedge clk);
        reset   = 1'b1;
        base_tx = n_tx;
        repeat (30) @(negedge clk);
        check("midrst_no_tx", 128'(n_tx - base_tx), 128'd0);
        wait_idle("post_rst", 20);
        send_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        run_pt("post_rst_pt", 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
